// File: rtl/dircc_accum_receive_handler_pkg.sv
// ----------------------------------------------------------------------------
// dircc_accum_receive_handler_pkg
// Shared types for the accumulating DiRCC receive handler:
//   - tick message / packet payload and device state layouts
//   - DiRCC run-state flag constants
//   - FIFO entry, user-state overlay and handler FSM encodings
// ----------------------------------------------------------------------------
package dircc_accum_receive_handler_pkg;

   // DiRCC run-state flags carried in device_state_t.dircc_state
   localparam logic [15:0] DIRCC_STATE_DONE    = 16'h0001;
   localparam logic [15:0] DIRCC_STATE_STOPPED = 16'h0002;
   localparam logic [15:0] DIRCC_STATE_DONE_STOPPED = DIRCC_STATE_DONE | DIRCC_STATE_STOPPED;

   // Tick message payload delivered by the packet router
   typedef struct packed {
      logic [31:0] count;
   } tick_msg_t;

   typedef tick_msg_t packet_data_t;

   // Thread device state as held in state memory
   typedef struct packed {
      logic [63:0] user_state;
      logic [15:0] dircc_state_extra;
      logic [15:0] dircc_state;
   } device_state_t;

   // Overlay of user_state used by the accumulator
   typedef struct packed {
      logic [15:0] rx_count;
      logic [47:0] acc;
   } acc_user_state_t;

   // Buffered packet: count is pre-masked to COUNT_WIDTH on entry
   typedef struct packed {
      logic [31:0] count;
      logic [7:0]  port_id;
   } acc_rx_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      UPDATE = 2'd2,
      WRITE  = 2'd3
   } acc_rx_fsm_t;

endpackage

// File: rtl/dircc_accum_receive_handler_fifo.sv
// ----------------------------------------------------------------------------
// dircc_rx_fifo
// Small synchronous FIFO with registered full/empty flags.
//   clk, reset_n  : clock, asynchronous active-low reset
//   push_i        : write push_data_i (taken when not full, or when popping)
//   push_data_i   : entry to store
//   pop_i         : retire head entry (ignored when empty)
//   pop_data_o    : head entry, valid while !empty_o
//   full_o        : registered, all DEPTH entries occupied
//   empty_o       : registered, no entries occupied
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module dircc_rx_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output T     pop_data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          do_push, do_pop;
   T              mem_q [DEPTH];

   assign do_pop  = pop_i && !empty_q;
   // A push on a full FIFO fits only because the head leaves the same cycle
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CW'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   // Storage needs no reset: entries are only read while counted as occupied
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;

endmodule

// File: rtl/dircc_accum_receive_handler.sv
// ----------------------------------------------------------------------------
// dircc_accum_receive_handler
// Buffers tick packets and accumulates their counts into thread device state
// through a handshaked read-modify-write. Flags DONE|STOPPED once the
// accumulator reaches the threshold.
//   clk, reset_n        : clock, asynchronous active-low reset
//   address             : thread address (reported on completion)
//   packet_in/port_id   : incoming tick payload and its input port
//   packet_in_valid     : packet present; taken when packet_in_ready
//   packet_in_ready     : buffer has room (registered)
//   total               : completion threshold
//   state_read_req      : one-cycle state read request
//   read_state(_valid)  : state read return
//   write_state(_valid) : updated state, held until write_state_ready
//   packet_handled      : pulse per retired packet (written or discarded)
//   dropped             : pulse per discarded packet
//   busy                : packet in flight or buffered
// ----------------------------------------------------------------------------
module dircc_accum_receive_handler
   import dircc_accum_receive_handler_pkg::*;
#(
   parameter int ADDRESS_MEM_WIDTH = 32,
   parameter int COUNT_WIDTH       = 16,
   parameter int ACC_WIDTH         = 48,
   parameter int FIFO_DEPTH        = 4,
   parameter int NUM_PORTS         = 4,
   parameter int SATURATE          = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDRESS_MEM_WIDTH-1:0] address,
   input  packet_data_t                 packet_in,
   input  logic [7:0]                   port_id,
   input  logic                         packet_in_valid,
   output logic                         packet_in_ready,
   input  logic [ACC_WIDTH-1:0]         total,
   output logic                         state_read_req,
   input  device_state_t                read_state,
   input  logic                         read_state_valid,
   output device_state_t                write_state,
   output logic                         write_state_valid,
   input  logic                         write_state_ready,
   output logic                         packet_handled,
   output logic                         dropped,
   output logic                         busy
);

   localparam logic [31:0] CNT_MASK = 32'((64'd1 << COUNT_WIDTH) - 64'd1);
   localparam logic [8:0]  NPORTS   = 9'(NUM_PORTS);

   // ---------------- packet buffer ----------------
   acc_rx_entry_t push_entry, head;
   logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

   assign push_entry.count   = packet_in.count & CNT_MASK;
   assign push_entry.port_id = port_id;
   assign packet_in_ready    = !fifo_full;
   assign fifo_push          = packet_in_valid && packet_in_ready;

   dircc_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (acc_rx_entry_t)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (fifo_push),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .pop_data_o  (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // ---------------- handler state ----------------
   acc_rx_fsm_t   state_q;
   logic [31:0]   cnt_q;
   device_state_t rd_q;
   device_state_t wr_q;
   logic          wr_vld_q, req_q, handled_q, dropped_q;

   assign fifo_pop = (state_q == IDLE) && !fifo_empty;

   // ---------------- update datapath ----------------
   logic [ACC_WIDTH:0]   sum_d;
   logic [ACC_WIDTH-1:0] res_d;
   device_state_t        upd_d;
   logic                 rd_done;
   logic                 reach_d;

   assign rd_done = (rd_q.dircc_state & DIRCC_STATE_DONE) != '0;

   always_comb begin
      // Extra bit catches the carry used for saturation
      sum_d   = {1'b0, rd_q.user_state[ACC_WIDTH-1:0]} + (ACC_WIDTH+1)'(cnt_q);
      res_d   = ((SATURATE != 0) && sum_d[ACC_WIDTH]) ? '1 : sum_d[ACC_WIDTH-1:0];
      reach_d = (res_d >= total);
      // Bits between ACC_WIDTH and 48 plus dircc_state_extra pass through
      upd_d   = rd_q;
      upd_d.user_state[63:48]          = rd_q.user_state[63:48] + 16'd1;
      upd_d.user_state[ACC_WIDTH-1:0] = res_d;
      if (reach_d) upd_d.dircc_state = DIRCC_STATE_DONE_STOPPED;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         wr_vld_q  <= 1'b0;
         req_q     <= 1'b0;
         handled_q <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         req_q     <= 1'b0;
         handled_q <= 1'b0;
         dropped_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  if ({1'b0, head.port_id} >= NPORTS) begin
                     handled_q <= 1'b1;
                     dropped_q <= 1'b1;
                  end else begin
                     cnt_q   <= head.count;
                     req_q   <= 1'b1;
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               if (read_state_valid) begin
                  rd_q    <= read_state;
                  state_q <= UPDATE;
               end
            end
            UPDATE: begin
               if (rd_done) begin
                  // Thread already finished: retire without touching state
                  handled_q <= 1'b1;
                  dropped_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  wr_q     <= upd_d;
                  wr_vld_q <= 1'b1;
                  state_q  <= WRITE;
               end
            end
            WRITE: begin
               if (write_state_ready) begin
                  handled_q <= 1'b1;
                  wr_vld_q  <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset_n && state_q == UPDATE && !rd_done && reach_d)
         $display("%0t: dircc_accum_receive_handler complete, address %h", $time, address);
   end
`endif

   assign state_read_req    = req_q;
   assign write_state       = wr_q;
   assign write_state_valid = wr_vld_q;
   assign packet_handled    = handled_q;
   assign dropped           = dropped_q;
   assign busy              = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dircc_accum_receive_handler.sv
// ----------------------------------------------------------------------------
// Directed bench for dircc_accum_receive_handler. dut0 uses the default
// parameters; dut_s / dut_w are 16-bit accumulator variants (saturating and
// wrapping) fed the same stimulus. A responder process models the state
// memory with a one-cycle read latency.
// ----------------------------------------------------------------------------
module tb_dircc_accum_receive_handler;
   import dircc_accum_receive_handler_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [31:0]   address;
   packet_data_t  packet_in;
   logic [7:0]    port_id;
   logic          packet_in_valid;
   logic [47:0]   total;
   device_state_t read_state;
   logic          read_state_valid;
   logic          write_state_ready;

   logic          rdy0, req0, wv0, hand0, drop0, busy0;
   device_state_t ws0;
   logic          rdy_s, req_s, wv_s, hand_s, drop_s, busy_s;
   device_state_t ws_s;
   logic          rdy_w, req_w, wv_w, hand_w, drop_w, busy_w;
   device_state_t ws_w;

   always #5 clk = ~clk;

   dircc_accum_receive_handler dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .packet_in(packet_in),
      .port_id(port_id), .packet_in_valid(packet_in_valid), .packet_in_ready(rdy0),
      .total(total), .state_read_req(req0), .read_state(read_state),
      .read_state_valid(read_state_valid), .write_state(ws0), .write_state_valid(wv0),
      .write_state_ready(write_state_ready), .packet_handled(hand0), .dropped(drop0),
      .busy(busy0));

   dircc_accum_receive_handler #(.COUNT_WIDTH(16), .ACC_WIDTH(16), .SATURATE(1)) dut_s (
      .clk(clk), .reset_n(reset_n), .address(address), .packet_in(packet_in),
      .port_id(port_id), .packet_in_valid(packet_in_valid), .packet_in_ready(rdy_s),
      .total(total[15:0]), .state_read_req(req_s), .read_state(read_state),
      .read_state_valid(read_state_valid), .write_state(ws_s), .write_state_valid(wv_s),
      .write_state_ready(write_state_ready), .packet_handled(hand_s), .dropped(drop_s),
      .busy(busy_s));

   dircc_accum_receive_handler #(.COUNT_WIDTH(16), .ACC_WIDTH(16), .SATURATE(0)) dut_w (
      .clk(clk), .reset_n(reset_n), .address(address), .packet_in(packet_in),
      .port_id(port_id), .packet_in_valid(packet_in_valid), .packet_in_ready(rdy_w),
      .total(total[15:0]), .state_read_req(req_w), .read_state(read_state),
      .read_state_valid(read_state_valid), .write_state(ws_w), .write_state_valid(wv_w),
      .write_state_ready(write_state_ready), .packet_handled(hand_w), .dropped(drop_w),
      .busy(busy_w));

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- state memory / event monitor ----------------
   device_state_t mem, preload_val, last_s, last_w;
   logic          preload_stb;
   device_state_t wq[$];
   int handled_cnt = 0, dropped_cnt = 0, both_cnt = 0, req_cnt = 0;
   int wcnt_s = 0, wcnt_w = 0;

   initial begin
      read_state_valid = 1'b0;
      read_state       = '0;
      mem              = '0;
      last_s           = '0;
      last_w           = '0;
      forever begin
         @(negedge clk);
         #2;
         if (preload_stb) mem = preload_val;
         // Request seen in this cycle is answered for the next edge
         read_state_valid = req0;
         read_state       = mem;
         if (hand0) handled_cnt++;
         if (drop0) dropped_cnt++;
         if (hand0 && drop0) both_cnt++;
         if (req0) req_cnt++;
         if (wv0 && write_state_ready) begin
            wq.push_back(ws0);
            mem = ws0;
         end
         if (wv_s && write_state_ready) begin last_s = ws_s; wcnt_s++; end
         if (wv_w && write_state_ready) begin last_w = ws_w; wcnt_w++; end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input device_state_t v);
      preload_val = v;
      preload_stb = 1'b1;
      @(negedge clk);
      preload_stb = 1'b0;
   endtask

   task automatic push(input logic [31:0] c, input logic [7:0] p);
      int n;
      packet_in.count = c;
      port_id         = p;
      packet_in_valid = 1'b1;
      n = 0;
      while (!rdy0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", 96'(rdy0), 96'(1'b1));
      @(negedge clk);
      packet_in_valid = 1'b0;
   endtask

   task automatic wait_handled(input int target);
      int n;
      n = 0;
      while (handled_cnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("handled_count", 96'(handled_cnt), 96'(target));
   endtask

   function automatic device_state_t mk(input logic [63:0] us, input logic [15:0] ex,
                                        input logic [15:0] st);
      device_state_t d;
      d.user_state        = us;
      d.dircc_state_extra = ex;
      d.dircc_state       = st;
      return d;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      int b, h, d, r, bs, bw, n;
      int acc_tab[6];
      acc_tab = '{1, 3, 6, 10, 15, 21};
      reset_n           = 1'b0;
      address           = 32'h1234_0040;
      packet_in         = '0;
      port_id           = 8'd0;
      packet_in_valid   = 1'b0;
      total             = '0;
      write_state_ready = 1'b1;
      preload_val       = '0;
      preload_stb       = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_ready",   96'(rdy0),  96'(1'b1));
      chk("rst_req",     96'(req0),  96'(1'b0));
      chk("rst_wvalid",  96'(wv0),   96'(1'b0));
      chk("rst_handled", 96'(hand0), 96'(1'b0));
      chk("rst_dropped", 96'(drop0), 96'(1'b0));
      chk("rst_busy",    96'(busy0), 96'(1'b0));
      chk("rst_wstate",  96'(ws0),   96'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // three packets accumulate to the threshold
      total = 48'd21;
      preload(mk(64'd0, 16'hABCD, 16'h0010));
      b = wq.size(); h = handled_cnt; d = dropped_cnt;
      push(32'd5, 8'd0);
      push(32'd7, 8'd0);
      push(32'd9, 8'd0);
      wait_handled(h + 3);
      chk("t1_writes", 96'(wq.size()), 96'(b + 3));
      if (wq.size() >= b + 3) begin
         chk("t1_w0_user",  96'(wq[b].user_state),          96'({16'd1, 48'd5}));
         chk("t1_w0_state", 96'(wq[b].dircc_state),         96'(16'h0010));
         chk("t1_w1_user",  96'(wq[b+1].user_state),        96'({16'd2, 48'd12}));
         chk("t1_w1_state", 96'(wq[b+1].dircc_state),       96'(16'h0010));
         chk("t1_w2_user",  96'(wq[b+2].user_state),        96'({16'd3, 48'd21}));
         chk("t1_w2_state", 96'(wq[b+2].dircc_state),       96'(16'h0003));
         chk("t1_w2_extra", 96'(wq[b+2].dircc_state_extra), 96'(16'hABCD));
      end
      chk("t1_no_drop", 96'(dropped_cnt), 96'(d));

      // out-of-range port is discarded without a read
      b = wq.size(); h = handled_cnt; d = dropped_cnt; r = req_cnt; n = both_cnt;
      push(32'd3, 8'd4);
      wait_handled(h + 1);
      chk("t2_dropped",   96'(dropped_cnt), 96'(d + 1));
      chk("t2_same_cyc",  96'(both_cnt),    96'(n + 1));
      chk("t2_no_req",    96'(req_cnt),     96'(r));
      chk("t2_no_write",  96'(wq.size()),   96'(b));

      // burst into a stalled write: buffer fills, then drains in order
      total = 48'd1000;
      preload(mk(64'd0, 16'h0000, 16'h0000));
      write_state_ready = 1'b0;
      b = wq.size(); h = handled_cnt;
      for (int i = 1; i <= 5; i++) push(32'(i), 8'((i - 1) % 4));
      // head packet already moved into the FSM, four remain buffered
      chk("t3_ready_low", 96'(rdy0),  96'(1'b0));
      chk("t3_busy",      96'(busy0), 96'(1'b1));
      repeat (4) @(negedge clk);
      chk("t3_wvalid_held", 96'(wv0),           96'(1'b1));
      chk("t3_wdata_held",  96'(ws0.user_state), 96'({16'd1, 48'd1}));
      chk("t3_still_full",  96'(rdy0),          96'(1'b0));
      write_state_ready = 1'b1;
      push(32'd6, 8'd1);
      wait_handled(h + 6);
      chk("t3_writes", 96'(wq.size()), 96'(b + 6));
      if (wq.size() >= b + 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("t3_order", 96'(wq[b+i].user_state), 96'({16'(i + 1), 48'(acc_tab[i])}));
         end
      end

      // saturation vs wrap in the 16-bit variants; dut0 just carries into bit 16
      total = 48'hFFFF_FFFF_FFFF;
      preload(mk(64'h0000_0000_0000_FFF0, 16'h0000, 16'h0000));
      h = handled_cnt; bs = wcnt_s; bw = wcnt_w;
      push(32'h20, 8'd0);
      wait_handled(h + 1);
      chk("t4_s_count", 96'(wcnt_s), 96'(bs + 1));
      chk("t4_w_count", 96'(wcnt_w), 96'(bw + 1));
      chk("t4_sat_user",   96'(last_s.user_state),  96'(64'h0001_0000_0000_FFFF));
      chk("t4_sat_state",  96'(last_s.dircc_state), 96'(16'h0003));
      chk("t4_wrap_user",  96'(last_w.user_state),  96'(64'h0001_0000_0000_0010));
      chk("t4_wrap_state", 96'(last_w.dircc_state), 96'(16'h0000));
      chk("t4_d0_user",    96'(wq[wq.size()-1].user_state), 96'(64'h0001_0000_0001_0010));

      // 48-bit saturation on dut0 reaches an all-ones threshold
      preload(mk(64'h0000_FFFF_FFFF_FFF0, 16'h0000, 16'h0000));
      h = handled_cnt;
      push(32'h20, 8'd0);
      wait_handled(h + 1);
      chk("t4b_user",  96'(wq[wq.size()-1].user_state),  96'(64'h0001_FFFF_FFFF_FFFF));
      chk("t4b_state", 96'(wq[wq.size()-1].dircc_state), 96'(16'h0003));

      // thread already DONE: read but no write
      total = 48'd1000;
      preload(mk(64'd100, 16'h0000, 16'h0001));
      b = wq.size(); h = handled_cnt; d = dropped_cnt; r = req_cnt;
      push(32'd3, 8'd2);
      wait_handled(h + 1);
      chk("t5_dropped",  96'(dropped_cnt), 96'(d + 1));
      chk("t5_no_write", 96'(wq.size()),   96'(b));
      chk("t5_read",     96'(req_cnt),     96'(r + 1));

      // zero threshold completes on a zero-count packet
      total = 48'd0;
      preload(mk(64'd0, 16'h0000, 16'h0000));
      h = handled_cnt;
      push(32'd0, 8'd3);
      wait_handled(h + 1);
      chk("t6_user",  96'(wq[wq.size()-1].user_state),  96'({16'd1, 48'd0}));
      chk("t6_state", 96'(wq[wq.size()-1].dircc_state), 96'(16'h0003));

      // reset during WRITE aborts the write and flushes the buffer
      total = 48'd1000;
      preload(mk(64'd0, 16'h0000, 16'h0000));
      write_state_ready = 1'b0;
      push(32'd4, 8'd0);
      push(32'd8, 8'd1);
      n = 0;
      while (!wv0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t7_in_write", 96'(wv0), 96'(1'b1));
      #1 reset_n = 1'b0;
      #1;
      chk("t7_async_wvalid", 96'(wv0),   96'(1'b0));
      chk("t7_rst_busy",     96'(busy0), 96'(1'b0));
      chk("t7_rst_ready",    96'(rdy0),  96'(1'b1));
      @(negedge clk);
      reset_n = 1'b1;
      write_state_ready = 1'b1;
      @(negedge clk);
      b = wq.size(); h = handled_cnt;
      preload(mk(64'd0, 16'h0000, 16'h0000));
      push(32'd2, 8'd0);
      wait_handled(h + 1);
      repeat (20) @(negedge clk);
      chk("t7_one_write", 96'(wq.size()),   96'(b + 1));
      chk("t7_one_retire", 96'(handled_cnt), 96'(h + 1));
      chk("t7_user", 96'(wq[wq.size()-1].user_state), 96'({16'd1, 48'd2}));
      chk("t7_idle", 96'(busy0), 96'(1'b0));

      // variants end idle as well
      chk("end_s_idle", 96'({rdy_s, req_s, wv_s, hand_s, drop_s, busy_s}), 96'(6'b100000));
      chk("end_w_idle", 96'({rdy_w, req_w, wv_w, hand_w, drop_w, busy_w}), 96'(6'b100000));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
